symbol_sequence_controller: RTL and testbench

//   Sequences the random 8-bit symbol stream into the associative memory: TRAIN phase presents

---
 rtl/sam_pkg.sv | 14 +
 rtl/noise_lfsr.sv | 35 +++
 rtl/symbol_sequence_controller.sv | 162 ++++++++++++++++
 tb/tb_symbol_sequence_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sam_pkg.sv
// Shared types and constants for the symbol sequencing path into the associative memory.
package sam_pkg;

    localparam int unsigned CNT_W     = 16;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRAIN  = 2'd1,
        RECALL = 2'd2,
        DONE   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/noise_lfsr.sv
// 16-bit right-shifting Galois LFSR selecting which symbol bit is flipped during RECALL.
module noise_lfsr
    import sam_pkg::*;
(
    input  logic        clk,
    input  logic        rstb,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] value
);

    logic [15:0] value_q;
    logic [15:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = seed;
        end else if (advance) begin
            value_d = {1'b0, value_q[15:1]} ^ (value_q[0] ? LFSR_TAPS : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            value_q <= seed;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/symbol_sequence_controller.sv
// Runs one TRAIN/RECALL episode per start pulse, presenting generator symbols to the memory
// through a valid/ready output register that holds stable under backpressure.
module symbol_sequence_controller
    import sam_pkg::*;
#(
    parameter int unsigned SYM_W      = 8,
    parameter int unsigned TRAIN_LEN  = 16,
    parameter int unsigned RECALL_LEN = 16,
    parameter bit          NOISE_EN   = 1'b1,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start,
    input  logic             abort,
    input  logic [SYM_W-1:0] sym_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] out_symbol,
    output logic [SYM_W-1:0] out_target,
    output logic             out_mode,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam int unsigned      IDX_W       = $clog2(SYM_W);
    localparam logic [CNT_W-1:0] TRAIN_LAST  = CNT_W'(TRAIN_LEN - 1);
    localparam logic [CNT_W-1:0] RECALL_LAST = (RECALL_LEN == 0) ? '0 : CNT_W'(RECALL_LEN - 1);

    seq_state_t       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [SYM_W-1:0] out_symbol_q, out_symbol_d;
    logic [SYM_W-1:0] out_target_q, out_target_d;
    logic             out_mode_q, out_mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    logic             lfsr_load;
    logic             lfsr_adv;
    logic [15:0]      lfsr_value;
    logic [IDX_W-1:0] noise_idx;
    logic [SYM_W-1:0] noise_mask;
    logic             xfer;

    noise_lfsr u_noise_lfsr (
        .clk     (clk),
        .rstb    (rstb),
        .load    (lfsr_load),
        .seed    (LFSR_SEED),
        .advance (lfsr_adv),
        .value   (lfsr_value)
    );

    assign xfer       = out_valid_q & out_ready;
    assign noise_idx  = IDX_W'(lfsr_value & 16'(SYM_W - 1));
    assign noise_mask = NOISE_EN ? (SYM_W'(1) << noise_idx) : '0;

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_symbol_d = out_symbol_q;
        out_target_d = out_target_q;
        out_mode_d   = out_mode_q;
        xfer_cnt_d   = xfer_cnt_q;
        lfsr_load    = 1'b0;
        lfsr_adv     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = TRAIN;
                    out_valid_d  = 1'b1;
                    out_symbol_d = sym_in;
                    out_target_d = sym_in;
                    out_mode_d   = 1'b0;
                    xfer_cnt_d   = '0;
                    lfsr_load    = 1'b1;
                end
            end
            TRAIN: begin
                if (xfer) begin
                    if (xfer_cnt_q != TRAIN_LAST) begin
                        xfer_cnt_d   = xfer_cnt_q + CNT_W'(1);
                        out_symbol_d = sym_in;
                        out_target_d = sym_in;
                    end else if (RECALL_LEN != 0) begin
                        // First RECALL symbol loads on the same edge so the stream has no bubble.
                        state_d      = RECALL;
                        xfer_cnt_d   = '0;
                        out_mode_d   = 1'b1;
                        out_target_d = sym_in;
                        out_symbol_d = sym_in ^ noise_mask;
                        lfsr_adv     = 1'b1;
                    end else begin
                        state_d     = DONE;
                        out_valid_d = 1'b0;
                        xfer_cnt_d  = xfer_cnt_q + CNT_W'(1);
                    end
                end
            end
            RECALL: begin
                if (xfer) begin
                    xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
                    if (xfer_cnt_q == RECALL_LAST) begin
                        state_d     = DONE;
                        out_valid_d = 1'b0;
                    end else begin
                        out_target_d = sym_in;
                        out_symbol_d = sym_in ^ noise_mask;
                        lfsr_adv     = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A coincident transfer is still accepted downstream, but abort owns the next state.
        if (abort && (state_q == TRAIN || state_q == RECALL)) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            xfer_cnt_d  = '0;
        end

        busy_d = (state_d == TRAIN) || (state_d == RECALL);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_symbol_q <= '0;
            out_target_q <= '0;
            out_mode_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            xfer_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_symbol_q <= out_symbol_d;
            out_target_q <= out_target_d;
            out_mode_q   <= out_mode_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            xfer_cnt_q   <= xfer_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_symbol = out_symbol_q;
    assign out_target = out_target_q;
    assign out_mode   = out_mode_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign xfer_cnt   = xfer_cnt_q;

endmodule

// File: tb/tb_symbol_sequence_controller.sv
// Directed bench: a 4/3 episode controller plus a 1/0 controller sharing clock, reset and stimulus.
module tb_symbol_sequence_controller;

    logic        clk = 1'b0;
    logic        rstb;
    logic        start;
    logic        start2;
    logic        abort;
    logic [7:0]  sym_in;
    logic        out_ready;

    logic        out_valid, out_mode, busy, done;
    logic [7:0]  out_symbol, out_target;
    logic [15:0] xfer_cnt;

    logic        s_valid, s_mode, s_busy, s_done;
    logic [7:0]  s_symbol, s_target;
    logic [15:0] s_xfer;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Driven symbols and the outputs they must produce; RECALL flips bit 1, 0, 0 from seed ACE1.
    logic [7:0]  drv     [8];
    logic [7:0]  exp_sym [7];
    logic [7:0]  exp_tgt [7];
    logic        exp_mode[7];
    logic [15:0] exp_x   [7];

    always #5 clk = ~clk;

    symbol_sequence_controller #(
        .SYM_W(8), .TRAIN_LEN(4), .RECALL_LEN(3), .NOISE_EN(1'b1), .LFSR_SEED(16'hACE1)
    ) u_dut (
        .clk(clk), .rstb(rstb), .start(start), .abort(abort), .sym_in(sym_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_symbol(out_symbol),
        .out_target(out_target), .out_mode(out_mode), .busy(busy), .done(done),
        .xfer_cnt(xfer_cnt)
    );

    symbol_sequence_controller #(
        .SYM_W(8), .TRAIN_LEN(1), .RECALL_LEN(0), .NOISE_EN(1'b1), .LFSR_SEED(16'hACE1)
    ) u_short (
        .clk(clk), .rstb(rstb), .start(start2), .abort(abort), .sym_in(sym_in),
        .out_valid(s_valid), .out_ready(out_ready), .out_symbol(s_symbol),
        .out_target(s_target), .out_mode(s_mode), .busy(s_busy), .done(s_done),
        .xfer_cnt(s_xfer)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input string tag, input bit hold_start, input int unsigned upto);
        start  = 1'b1;
        sym_in = drv[0];
        tick();
        start = hold_start;
        for (int unsigned i = 0; i <= upto; i++) begin
            check($sformatf("%s_valid%0d", tag, i), 32'(out_valid), 32'd1);
            check($sformatf("%s_sym%0d", tag, i), 32'(out_symbol), 32'(exp_sym[i]));
            check($sformatf("%s_tgt%0d", tag, i), 32'(out_target), 32'(exp_tgt[i]));
            check($sformatf("%s_mode%0d", tag, i), 32'(out_mode), 32'(exp_mode[i]));
            check($sformatf("%s_xfer%0d", tag, i), 32'(xfer_cnt), 32'(exp_x[i]));
            check($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
            if (i < upto) begin
                sym_in = drv[i + 1];
                tick();
            end
        end
    endtask

    task automatic finish_seq(input string tag);
        sym_in = drv[7];
        tick();
        check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_done_pulse"}, 32'(done), 32'd1);
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
        check({tag, "_done_xfer"}, 32'(xfer_cnt), 32'd3);
    endtask

    task automatic after_done(input string tag);
        tick();
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_xfer"}, 32'(xfer_cnt), 32'd3);
    endtask

    task automatic wait_done(input string tag, input int unsigned max_cycles);
        bit seen = 1'b0;
        for (int unsigned c = 0; c < max_cycles && !seen; c++) begin
            tick();
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        drv      = '{8'hFF, 8'hF0, 8'hCC, 8'hAA, 8'hFF, 8'hF0, 8'hCC, 8'hAA};
        exp_sym  = '{8'hFF, 8'hF0, 8'hCC, 8'hAA, 8'hFD, 8'hF1, 8'hCD};
        exp_tgt  = '{8'hFF, 8'hF0, 8'hCC, 8'hAA, 8'hFF, 8'hF0, 8'hCC};
        exp_mode = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_x    = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1, 16'd2};

        rstb = 1'b0; start = 1'b0; start2 = 1'b0; abort = 1'b0;
        sym_in = 8'h00; out_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sym", 32'(out_symbol), 32'd0);
        check("rst_tgt", 32'(out_target), 32'd0);
        check("rst_mode", 32'(out_mode), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_xfer", 32'(xfer_cnt), 32'd0);
        check("rst_s_valid", 32'(s_valid), 32'd0);
        rstb = 1'b1;
        tick();

        // 1: full episode, ready always high
        run_seq("s1", 1'b0, 6);
        finish_seq("s1");
        after_done("s1");

        // 2: backpressure mid-TRAIN
        start = 1'b1; sym_in = 8'hFF;
        tick();
        start = 1'b0; sym_in = 8'hF0;
        tick();
        out_ready = 1'b0; sym_in = 8'h55;
        for (int unsigned k = 0; k < 5; k++) begin
            tick();
            check($sformatf("s2_hold_valid%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("s2_hold_sym%0d", k), 32'(out_symbol), 32'h0F0);
            check($sformatf("s2_hold_tgt%0d", k), 32'(out_target), 32'h0F0);
            check($sformatf("s2_hold_xfer%0d", k), 32'(xfer_cnt), 32'd1);
        end
        out_ready = 1'b1; sym_in = 8'hCC;
        tick();
        check("s2_resume_sym", 32'(out_symbol), 32'h0CC);
        check("s2_resume_xfer", 32'(xfer_cnt), 32'd2);
        wait_done("s2", 20);
        tick();

        // 3: TRAIN_LEN=1, RECALL_LEN=0
        start2 = 1'b1; sym_in = 8'h3C;
        tick();
        start2 = 1'b0;
        check("s3_valid", 32'(s_valid), 32'd1);
        check("s3_sym", 32'(s_symbol), 32'h03C);
        check("s3_mode", 32'(s_mode), 32'd0);
        check("s3_busy", 32'(s_busy), 32'd1);
        tick();
        check("s3_done_valid", 32'(s_valid), 32'd0);
        check("s3_done_pulse", 32'(s_done), 32'd1);
        check("s3_done_mode", 32'(s_mode), 32'd0);
        check("s3_done_xfer", 32'(s_xfer), 32'd1);
        tick();
        check("s3_idle_done", 32'(s_done), 32'd0);
        check("s3_main_idle", 32'(busy), 32'd0);

        // 4: abort in RECALL at xfer_cnt=1, then the rerun must reproduce the noise pattern
        run_seq("s4", 1'b0, 5);
        abort = 1'b1; sym_in = drv[6];
        tick();
        abort = 1'b0;
        check("s4_abort_valid", 32'(out_valid), 32'd0);
        check("s4_abort_busy", 32'(busy), 32'd0);
        check("s4_abort_done", 32'(done), 32'd0);
        check("s4_abort_xfer", 32'(xfer_cnt), 32'd0);
        for (int unsigned k = 0; k < 3; k++) begin
            tick();
            check($sformatf("s4_no_done%0d", k), 32'(done), 32'd0);
        end
        run_seq("s4r", 1'b0, 6);
        finish_seq("s4r");
        after_done("s4r");

        // 5: start held high through the whole episode and DONE
        run_seq("s5", 1'b1, 6);
        finish_seq("s5");
        tick();
        check("s5_ignored_busy", 32'(busy), 32'd0);
        check("s5_ignored_valid", 32'(out_valid), 32'd0);
        start = 1'b0;
        tick();
        check("s5_idle_busy", 32'(busy), 32'd0);

        // 6: one-cycle reset mid-TRAIN, then a clean episode
        run_seq("s6", 1'b0, 2);
        rstb = 1'b0; sym_in = drv[3];
        tick();
        check("s6_rst_valid", 32'(out_valid), 32'd0);
        check("s6_rst_sym", 32'(out_symbol), 32'd0);
        check("s6_rst_tgt", 32'(out_target), 32'd0);
        check("s6_rst_mode", 32'(out_mode), 32'd0);
        check("s6_rst_busy", 32'(busy), 32'd0);
        check("s6_rst_done", 32'(done), 32'd0);
        check("s6_rst_xfer", 32'(xfer_cnt), 32'd0);
        rstb = 1'b1;
        tick();
        run_seq("s6r", 1'b0, 6);
        finish_seq("s6r");
        after_done("s6r");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
